// File: rtl/alu_multicycle.sv
// ALU opcodes plus the execute-side ALU: single-cycle arithmetic/logic,
// bit-serial shifts, valid/ready on both the operation and result sides.
package definitions_pkg;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
endpackage

module alu_multicycle
  import definitions_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_op;
  logic [4:0]       w_op_d;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_d;
  logic [SW-1:0]    r_cnt;
  logic [SW-1:0]    w_cnt_d;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_d;
  logic             r_ill;
  logic             w_ill_d;

  logic [SW-1:0]    w_shamt;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_alu;
  logic             w_undef;
  logic [WIDTH-1:0] w_step;

  assign w_shamt    = SrcB[SW-1:0];
  assign w_is_shift = (ALUControl == ALU_SLL) ||
                      (ALUControl == ALU_SRL) ||
                      (ALUControl == ALU_SRA);

  // Single-cycle result; shifts only reach here with shamt==0.
  always_comb begin
    w_alu   = '0;
    w_undef = 1'b0;
    unique case (ALUControl)
      ALU_ADD:  w_alu = SrcA + SrcB;
      ALU_SUB:  w_alu = SrcA - SrcB;
      ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}},
                         $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      ALU_XOR:  w_alu = SrcA ^ SrcB;
      ALU_OR:   w_alu = SrcA | SrcB;
      ALU_AND:  w_alu = SrcA & SrcB;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_alu = SrcA;
      default:  w_undef = 1'b1;
    endcase
  end

  always_comb begin
    w_step = r_acc;
    unique case (r_op)
      ALU_SLL: w_step = {r_acc[WIDTH-2:0], 1'b0};
      ALU_SRL: w_step = {1'b0, r_acc[WIDTH-1:1]};
      ALU_SRA: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_step = r_acc;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_op_d  = r_op;
    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    w_res_d = r_res;
    w_ill_d = r_ill;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_op_d  = ALUControl;
          w_acc_d = SrcA;
          w_cnt_d = w_shamt;
          if (w_is_shift && (w_shamt != '0)) begin
            w_next = S_SHIFT;
          end else begin
            w_next  = S_DONE;
            w_res_d = w_alu;
            w_ill_d = w_undef;
          end
        end
      end
      S_SHIFT: begin
        w_acc_d = w_step;
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == SW'(1)) begin
          w_next  = S_DONE;
          w_res_d = w_step;
          w_ill_d = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_op    <= w_op_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_res   <= w_res_d;
      r_ill   <= w_ill_d;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign ALUResult = r_res;
  assign Zero      = (r_res == '0);
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: arithmetic, compares, serial
// shifts, backpressure, illegal opcodes and reset mid-shift.
module tb_alu_multicycle;
  import definitions_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal;

  int cmp_cnt;
  int err_cnt;
  int lat;
  bit seen;
  bit ok;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op, then wait (bounded) for out_valid; lat=1 means
  // out_valid already high right after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int l);
    @(negedge clk);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  // Let the handoff edge pass (out_ready must be 1).
  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_cnt    = 0;
    err_cnt    = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = '0;
    SrcA       = '0;
    SrcB       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", ALUResult, 32'h0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, lat);
    chk("add_lat", lat, 1);
    chk("add_res", ALUResult, 32'h0);
    chk("add_zero", 32'(Zero), 32'd1);
    chk("add_in_ready", 32'(in_ready), 32'd0);
    drain();
    chk("add_idle", 32'(in_ready), 32'd1);

    issue(ALU_SUB, 32'd5, 32'd7, lat);
    chk("sub_res", ALUResult, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(Zero), 32'd0);
    drain();

    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_res", ALUResult, 32'd1);
    drain();
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu_res", ALUResult, 32'd0);
    drain();
    issue(ALU_SLT, 32'd3, 32'd3, lat);
    chk("slt_eq_res", ALUResult, 32'd0);
    chk("slt_eq_zero", 32'(Zero), 32'd1);
    drain();

    issue(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
    chk("xor_res", ALUResult, 32'hFF00_EDCB);
    drain();
    issue(ALU_OR, 32'hF000_000F, 32'h0000_0F00, lat);
    chk("or_res", ALUResult, 32'hF000_0F0F);
    drain();
    issue(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, lat);
    chk("and_res", ALUResult, 32'h0F00_0F00);
    drain();

    issue(ALU_SRA, 32'h8000_0000, 32'd31, lat);
    chk("sra_lat", lat, 32);
    chk("sra_res", ALUResult, 32'hFFFF_FFFF);
    drain();
    issue(ALU_SRL, 32'h8000_0000, 32'd31, lat);
    chk("srl_lat", lat, 32);
    chk("srl_res", ALUResult, 32'h0000_0001);
    drain();
    issue(ALU_SLL, 32'h1, 32'h23, lat);
    chk("sll_lat", lat, 4);
    chk("sll_res", ALUResult, 32'h8);
    drain();
    issue(ALU_SRA, 32'hA5A5_0000, 32'h40, lat);
    chk("sh0_lat", lat, 1);
    chk("sh0_res", ALUResult, 32'hA5A5_0000);
    drain();
    issue(ALU_SRA, 32'hF000_0000, 32'd4, lat);
    chk("sra4_res", ALUResult, 32'hFF00_0000);
    drain();

    out_ready = 1'b0;
    issue(ALU_ADD, 32'd10, 32'd20, lat);
    chk("bp_first", ALUResult, 32'd30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      ALUControl = ALU_SUB;
      SrcA       = 32'(i);
      SrcB       = 32'd99;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hold_res", ALUResult, 32'd30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_keep_res", ALUResult, 32'd30);

    issue(5'b11111, 32'd5, 32'd6, lat);
    chk("ill_lat", lat, 1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_res", ALUResult, 32'h0);
    chk("ill_zero", 32'(Zero), 32'd1);
    drain();
    issue(ALU_ADD, 32'd1, 32'd1, lat);
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("ill_next_res", ALUResult, 32'd2);
    drain();

    @(negedge clk);
    ALUControl = ALU_SRL;
    SrcA       = 32'hFFFF_FFFF;
    SrcB       = 32'd20;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res", ALUResult, 32'h0);
    chk("mid_rst_zero", 32'(Zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
